// File: rtl/pq_sched_pkg.sv
// Shared constants for the spike-packet priority-queue scheduler.
package pq_sched_pkg;

  // Default geometry of the requester array and packet format.
  localparam int DEF_NUM_PORTS   = 4;
  localparam int DEF_PACKET_SIZE = 32;
  localparam int DEF_SEQ_START   = 4;
  localparam int DEF_SEQ_WIDTH   = 4;

  // Scheduler FSM encoding.
  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_DRAIN  = 1'b1;

endpackage

// File: rtl/pq_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] grant_d;
  logic [PTR_W-1:0]     idx;
  logic                 found;

  // Pick the first requester after the pointer; pointer moves only on a grant.
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    if (enable) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
        if (!found && req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          ptr_d        = idx;
        end
      end
    end
  end

  assign grant = grant_d;

  // Last-granted pointer; reset value makes port 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTR_W'(NUM_PORTS - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pq_scheduler.sv
// Priority-queue scheduler: accepts spike packets into the queue during a
// time step, then drains the packets of that step to the output on tick.
//
// state  | meaning
// ACCEPT | arbitrate requesters into the queue for current_seq
// DRAIN  | pop queue entries whose seq equals current_seq to the output
module pq_scheduler
  import pq_sched_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int PACKET_SIZE = DEF_PACKET_SIZE,
  parameter int SEQ_START   = DEF_SEQ_START,
  parameter int SEQ_WIDTH   = DEF_SEQ_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS*PACKET_SIZE-1:0] req_data,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic                             tick,
  output logic [SEQ_WIDTH-1:0]             current_seq,
  output logic                             q_wrEn,
  output logic [PACKET_SIZE-1:0]           q_wrData,
  output logic                             q_rdEn,
  input  logic [PACKET_SIZE-1:0]           q_rdData,
  input  logic                             q_full,
  input  logic                             q_empty,
  input  logic                             q_busy,
  output logic                             out_valid,
  output logic [PACKET_SIZE-1:0]           out_data,
  input  logic                             out_ready,
  output logic                             tick_overrun
);

  logic [0:0]             state_q, state_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic                   out_valid_q, out_valid_d;
  logic [PACKET_SIZE-1:0] out_data_q, out_data_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;

  logic [SEQ_WIDTH-1:0]   head_seq;
  logic                   head_match;
  logic                   in_accept, in_drain;
  logic                   arb_en, drain_rd, drain_done;
  logic [NUM_PORTS-1:0]   grant;

  // Status decode; everything that drives the queue is suppressed under reset.
  always_comb begin
    head_seq   = q_rdData[SEQ_START +: SEQ_WIDTH];
    head_match = !q_empty && (head_seq == seq_q);
    in_accept  = !rst && (state_q == ST_ACCEPT);
    in_drain   = !rst && (state_q == ST_DRAIN);
    // A pending tick turns ACCEPT straight back into DRAIN, so no grant then.
    arb_en     = in_accept && !tick && !pending_q && !q_full && !q_busy;
    drain_rd   = in_drain && !q_busy && head_match && (!out_valid_q || out_ready);
    drain_done = in_drain && !q_busy && !head_match;
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .enable (arb_en),
    .grant  (grant)
  );

  // Forward the granted requester's packet to the queue write port.
  always_comb begin
    q_wrData = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) q_wrData = q_wrData | req_data[i*PACKET_SIZE +: PACKET_SIZE];
    end
  end

  assign req_ready    = grant;
  assign q_wrEn       = |grant;
  assign q_rdEn       = drain_rd;
  assign current_seq  = seq_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign tick_overrun = overrun_q;

  // FSM, time-step counter and tick bookkeeping.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (state_q == ST_ACCEPT) begin
      if (pending_q) begin
        state_d   = ST_DRAIN;
        pending_d = 1'b0;
        if (tick) overrun_d = 1'b1;
      end else if (tick) begin
        state_d = ST_DRAIN;
      end
    end else begin
      if (tick) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end
      if (drain_done) begin
        seq_d   = seq_q + SEQ_WIDTH'(1);
        state_d = ST_ACCEPT;
      end
    end
  end

  // Output register: load on a queue read, release on downstream accept.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (drain_rd) begin
      out_valid_d = 1'b1;
      out_data_d  = q_rdData;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pq_scheduler.sv
// Directed bench for pq_scheduler with a queue stand-in and a behavioural model.
module tb_pq_scheduler;

  localparam int NP = 4;
  localparam int PS = 32;
  localparam int SS = 4;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP*PS-1:0]  req_data;
  logic [NP-1:0]     req_ready;
  logic              tick;
  logic [SW-1:0]     current_seq;
  logic              q_wrEn;
  logic [PS-1:0]     q_wrData;
  logic              q_rdEn;
  logic [PS-1:0]     q_rdData = '0;
  logic              q_full;
  logic              q_empty = 1'b1;
  logic              q_busy;
  logic              out_valid;
  logic [PS-1:0]     out_data;
  logic              out_ready;
  logic              tick_overrun;

  pq_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tick         (tick),
    .current_seq  (current_seq),
    .q_wrEn       (q_wrEn),
    .q_wrData     (q_wrData),
    .q_rdEn       (q_rdEn),
    .q_rdData     (q_rdData),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .q_busy       (q_busy),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pkt(input int port, input int seq);
    return 32'hA000_0000 | 32'((port & 255) << 16) | 32'((seq & 15) << SS);
  endfunction

  // Queue stand-in: simple FIFO whose head is presented on q_rdData.
  logic [31:0] fifo[$];
  logic        wr_l = 1'b0, rd_l = 1'b0;
  logic [31:0] wrd_l = '0;

  // Model state (current) and next values computed at the falling edge.
  bit          m_known = 0, n_known = 0;
  bit          m_drain, n_drain;
  int          m_seq, n_seq, m_last, n_last;
  bit          m_ov, n_ov, m_pend, n_pend, m_ovr, n_ovr;
  logic [31:0] m_od, n_od;

  int rd_cnt = 0;
  int beat_cnt = 0;

  // Compare process: predict this cycle's outputs from the model, check, plan next state.
  always @(negedge clk) begin
    int          gidx;
    int          head;
    logic [NP-1:0] e_grant;
    bit          e_rd;
    gidx = -1;
    e_grant = '0;
    if (!rst && !m_drain && !tick && !m_pend && !q_full && !q_busy) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (gidx < 0 && req_valid[p]) gidx = p;
      end
    end
    if (gidx >= 0) e_grant[gidx] = 1'b1;
    head = int'((q_rdData >> SS) & 32'hF);
    e_rd = !rst && m_drain && !q_busy && !q_empty && (head == m_seq) && (!m_ov || out_ready);

    if (m_known) begin
      chk("req_ready", 32'(req_ready), 32'(e_grant));
      chk("q_wrEn", 32'(q_wrEn), 32'(gidx >= 0));
      if (gidx >= 0) chk("q_wrData", q_wrData, req_data[gidx*PS +: PS]);
      chk("q_rdEn", 32'(q_rdEn), 32'(e_rd));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", out_data, m_od);
      chk("current_seq", 32'(current_seq), 32'(m_seq));
      chk("tick_overrun", 32'(tick_overrun), 32'(m_ovr));
    end

    if (q_rdEn === 1'b1) rd_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) beat_cnt++;
    wr_l  = (q_wrEn === 1'b1);
    rd_l  = (q_rdEn === 1'b1);
    wrd_l = q_wrData;

    n_known = m_known; n_drain = m_drain; n_seq = m_seq; n_last = m_last;
    n_ov = m_ov; n_od = m_od; n_pend = m_pend; n_ovr = m_ovr;
    if (rst) begin
      n_known = 1; n_drain = 0; n_seq = 0; n_last = NP - 1;
      n_ov = 0; n_od = '0; n_pend = 0; n_ovr = 0;
    end else begin
      if (!m_drain) begin
        if (m_pend) begin
          n_drain = 1; n_pend = 0;
          if (tick) n_ovr = 1;
        end else if (tick) begin
          n_drain = 1;
        end else if (gidx >= 0) begin
          n_last = gidx;
        end
      end else begin
        if (tick) begin
          if (m_pend) n_ovr = 1;
          else        n_pend = 1;
        end
        if (!q_busy && !(!q_empty && head == m_seq)) begin
          n_seq = (m_seq + 1) % 16;
          n_drain = 0;
        end
      end
      if (e_rd) begin
        n_ov = 1; n_od = q_rdData;
      end else if (out_ready) begin
        n_ov = 0;
      end
    end
  end

  // Rising edge: commit model, apply queue push/pop, refresh queue head.
  always @(posedge clk) begin
    m_known = n_known; m_drain = n_drain; m_seq = n_seq; m_last = n_last;
    m_ov = n_ov; m_od = n_od; m_pend = n_pend; m_ovr = n_ovr;
    if (wr_l) fifo.push_back(wrd_l);
    if (rd_l && fifo.size() > 0) void'(fifo.pop_front());
    q_rdData <= (fifo.size() > 0) ? fifo[0] : '0;
    q_empty  <= (fifo.size() == 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_data = '0; tick = 1'b0;
    q_full = 1'b0; q_busy = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    mid();
    chk("rst_seq", 32'(current_seq), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(tick_overrun), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdEn", 32'(q_rdEn), 32'd0);
    cyc();

    // All four ports requesting: grants rotate 0,1,2,3,0.
    rst = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < NP; i++) req_data[i*PS +: PS] = pkt(i, 0);
    for (int j = 0; j < 5; j++) begin
      mid();
      chk("rr_order", 32'(req_ready), 32'(1 << order[j]));
      if (j == 0) chk("rr_wrdata", q_wrData, 32'hA000_0000);
      cyc();
    end

    // Queue busy for three cycles: nothing granted; then port 1 wins.
    q_busy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mid();
      chk("busy_ready", 32'(req_ready), 32'd0);
      chk("busy_wrEn", 32'(q_wrEn), 32'd0);
      cyc();
    end
    q_busy = 1'b0;
    mid();
    chk("after_busy", 32'(req_ready), 32'b0010);
    cyc();

    // Queue full blocks the grant.
    req_valid = 4'b0100;
    q_full = 1'b1;
    mid();
    chk("full_ready", 32'(req_ready), 32'd0);
    cyc();
    q_full = 1'b0;
    mid();
    chk("unfull_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;

    // Drain of seq 0 with entries 0,0,1.
    fifo.delete();
    fifo.push_back(pkt(0, 0));
    fifo.push_back(pkt(1, 0));
    fifo.push_back(pkt(2, 1));
    cyc();
    rd_cnt = 0; beat_cnt = 0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (6) cyc();
    chk("drain_rd_pulses", 32'(rd_cnt), 32'd2);
    chk("drain_beats", 32'(beat_cnt), 32'd2);
    chk("drain_seq", 32'(current_seq), 32'd1);
    chk("drain_left", 32'(fifo.size()), 32'd1);
    chk("drain_left_pkt", fifo[0], pkt(2, 1));
    req_valid = 4'b0001;
    req_data[0 +: PS] = pkt(0, 1);
    mid();
    chk("back_in_accept", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;

    // Back-pressure during drain: one packet held, no further read.
    out_ready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    for (int j = 0; j < 3; j++) begin
      mid();
      chk("hold_rdEn", 32'(q_rdEn), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, pkt(2, 1));
      cyc();
    end
    out_ready = 1'b1;
    mid();
    chk("release_rdEn", 32'(q_rdEn), 32'd1);
    cyc();
    mid();
    chk("second_pkt", out_data, pkt(0, 1));
    repeat (4) cyc();
    chk("hold_seq", 32'(current_seq), 32'd2);
    chk("hold_empty", 32'(fifo.size()), 32'd0);

    // Two ticks in one drain: overrun, one extra drain, seq +2.
    q_busy = 1'b1;
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; q_busy = 1'b0;
    repeat (5) cyc();
    chk("overrun_flag", 32'(tick_overrun), 32'd1);
    chk("overrun_seq", 32'(current_seq), 32'd4);

    // Empty drains walk seq up to 15 and then wrap to 0.
    for (int j = 0; j < 11; j++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; repeat (3) cyc();
    end
    chk("seq_15", 32'(current_seq), 32'd15);
    tick = 1'b1; cyc();
    tick = 1'b0; repeat (3) cyc();
    chk("seq_wrap", 32'(current_seq), 32'd0);

    // Reset in the middle of a drain: no read issued afterwards.
    fifo.push_back(pkt(1, 0));
    q_busy = 1'b1;
    cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    rst = 1'b1; q_busy = 1'b0;
    mid();
    chk("rst_mid_rdEn", 32'(q_rdEn), 32'd0);
    cyc();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      mid();
      chk("post_rst_rdEn", 32'(q_rdEn), 32'd0);
      cyc();
    end
    chk("post_rst_overrun", 32'(tick_overrun), 32'd0);
    chk("post_rst_seq", 32'(current_seq), 32'd0);
    chk("post_rst_fifo", 32'(fifo.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pq_scheduler.md
PQ_SCHEDULER -- requirements
Module: pq_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NUM_PORTS, 4, number of spike-packet requesters sharing the priority queue.
  PACKET_SIZE, 32, packet width in bits.
  SEQ_START, 4, LSB of the sequence (time-step) field in a packet.
  SEQ_WIDTH, 4, width of the sequence field.
REQ-002 The block SHALL use one clock, clk, and one reset, rst; rst is synchronous and active-high.
REQ-003 Ports SHALL be exactly these, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  rst  in  1  synchronous active-high reset.
  req_valid  in  NUM_PORTS  requester i holds a packet.
  req_data  in  NUM_PORTS*PACKET_SIZE  packet of requester i at slice [i*PACKET_SIZE +: PACKET_SIZE].
  req_ready  out  NUM_PORTS  one-hot grant; the packet is consumed when valid and ready are both high.
  tick  in  1  single-cycle time-step-end pulse.
  current_seq  out  SEQ_WIDTH  time step being accumulated; drives queue currentSeqNum.
  q_wrEn  out  1  queue write enable.
  q_wrData  out  PACKET_SIZE  queue write data.
  q_rdEn  out  1  queue read enable.
  q_rdData  in  PACKET_SIZE  queue head packet.
  q_full, q_empty, q_busy  in  1 each  queue status.
  out_valid  out  1  delivered packet valid.
  out_data  out  PACKET_SIZE  delivered packet, registered.
  out_ready  in  1  downstream accepts.
  tick_overrun  out  1  sticky: a tick was lost.

Function
REQ-004 FSM states SHALL be ACCEPT and DRAIN only.
REQ-005 In ACCEPT, a grant SHALL be issued only when q_full=0 and q_busy=0; at most one grant per cycle.
REQ-006 Arbitration SHALL be round-robin: search starts at last granted port +1, modulo NUM_PORTS; the pointer updates only on a grant.
REQ-007 A grant SHALL drive q_wrEn=1 and q_wrData=req_data of the granted port in the same cycle, combinationally; q_wrEn SHALL never be high when q_full or q_busy is high.
REQ-008 A tick in ACCEPT SHALL move the FSM to DRAIN at the next edge; no grant is issued in the tick cycle.
REQ-009 In DRAIN, req_ready SHALL be all-zero and q_wrEn SHALL be 0.
REQ-010 In DRAIN, the block SHALL assert q_rdEn for one cycle when all of the following hold: q_empty=0, q_busy=0, q_rdData[SEQ_START +: SEQ_WIDTH]==current_seq, and (out_valid=0 or out_ready=1). In that same cycle it SHALL load q_rdData into out_data, with out_valid=1 at the next edge.
REQ-011 Drain completion: in DRAIN with q_busy=0 and (q_empty=1 or head seq != current_seq), the block SHALL increment current_seq modulo 2^SEQ_WIDTH and return to ACCEPT at the next edge.
REQ-012 out_valid SHALL clear on out_ready unless a new load happens in the same cycle; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-013 A tick received in DRAIN SHALL set a 1-bit pending flag; a second tick while the flag is set SHALL set tick_overrun.
REQ-014 On return to ACCEPT with the pending flag set, the FSM SHALL re-enter DRAIN immediately and clear the flag.
REQ-015 A tick coincident with the completion cycle SHALL be treated as pending.
REQ-016 The drain read latency SHALL be 1 cycle from q_rdEn to out_valid.

Reset
REQ-017 With rst=1 at an edge, the block SHALL set: state=ACCEPT; current_seq=0; RR pointer=NUM_PORTS-1 (port 0 served first); out_valid=0; out_data=0; pending=0; tick_overrun=0.
REQ-018 While rst=1, req_ready, q_wrEn and q_rdEn SHALL be 0.
REQ-019 Reset mid-DRAIN SHALL abandon the drain; no further q_rdEn is issued.

Structure
REQ-020 A package pq_sched_pkg SHALL hold the state enum, the SEQ field helper constants and default widths.
REQ-021 The arbiter SHALL be one sub-module, rr_arbiter (NUM_PORTS parameter; inputs req, enable; output one-hot grant; internal pointer).

Verification
REQ-022 The bench SHALL cover these directed scenarios.
  All 4 ports valid in ACCEPT, queue idle -> grants in order 0,1,2,3,0, one per non-busy cycle.
  q_busy=1 for 3 cycles -> no req_ready or q_wrEn during those cycles.
  current_seq=0; queue holds seq 0,0,1; tick, out_ready=1 -> two q_rdEn pulses, two out_valid beats, current_seq=1, FSM back in ACCEPT, seq-1 packet remains.
  out_ready=0 during DRAIN -> one packet held, q_rdEn low until out_ready=1.
  Two ticks during one DRAIN -> tick_overrun=1; one extra DRAIN; current_seq advances by 2 in total.
  current_seq=15; tick with queue empty -> current_seq=0 (wrap).
